// File: rtl/reg_file_scoreboard.sv
// Three-read, two-write register file with write-through bypass and a
// pending-write scoreboard feeding the decode stall logic.
module reg_file_scoreboard #(
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int RESET_INDEX = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb0_en,
    input  logic [ADDR_WIDTH-1:0]         wb0_dest,
    input  logic [WORD_WIDTH-1:0]         wb0_result,
    input  logic                          wb1_en,
    input  logic [ADDR_WIDTH-1:0]         wb1_dest,
    input  logic [WORD_WIDTH-1:0]         wb1_result,
    input  logic [ADDR_WIDTH-1:0]         src1,
    input  logic [ADDR_WIDTH-1:0]         src2,
    input  logic [ADDR_WIDTH-1:0]         src3,
    output logic [WORD_WIDTH-1:0]         reg1,
    output logic [WORD_WIDTH-1:0]         reg2,
    output logic [WORD_WIDTH-1:0]         reg3,
    output logic                          hazard1,
    output logic                          hazard2,
    output logic                          hazard3,
    input  logic                          issue_en,
    input  logic [ADDR_WIDTH-1:0]         issue_dest,
    output logic                          issue_ready,
    input  logic                          flush,
    output logic [(1<<ADDR_WIDTH)-1:0]    pending_mask
);

    localparam int REG_COUNT = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] regs_q [REG_COUNT];
    logic [WORD_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  pending_q;
    logic [REG_COUNT-1:0]  pending_d;
    logic [REG_COUNT-1:0]  wr_hit;

    logic [2:0][ADDR_WIDTH-1:0] src;
    logic [2:0][WORD_WIDTH-1:0] rdata;
    logic [2:0]                 hazard;

    always_comb begin
        wr_hit = '0;
        if (wb0_en) wr_hit[wb0_dest] = 1'b1;
        if (wb1_en) wr_hit[wb1_dest] = 1'b1;
    end

    // Port 1 is applied last so it wins on a shared destination.
    always_comb begin
        regs_d = regs_q;
        if (wb0_en) regs_d[wb0_dest] = wb0_result;
        if (wb1_en) regs_d[wb1_dest] = wb1_result;
    end

    // Issue overrides completion on the same index; flush overrides both.
    always_comb begin
        pending_d = pending_q & ~wr_hit;
        if (issue_en) pending_d[issue_dest] = 1'b1;
        if (flush) pending_d = '0;
    end

    always_comb begin
        src = {src3, src2, src1};
        rdata = '0;
        hazard = '0;
        for (int k = 0; k < 3; k++) begin
            if (wb1_en && wb1_dest == src[k]) begin
                rdata[k] = wb1_result;
            end else if (wb0_en && wb0_dest == src[k]) begin
                rdata[k] = wb0_result;
            end else begin
                rdata[k] = regs_q[src[k]];
            end
            hazard[k] = pending_q[src[k]] & ~wr_hit[src[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (RESET_INDEX != 0) ? WORD_WIDTH'(i) : '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign reg1         = rdata[0];
    assign reg2         = rdata[1];
    assign reg3         = rdata[2];
    assign hazard1      = hazard[0];
    assign hazard2      = hazard[1];
    assign hazard3      = hazard[2];
    assign issue_ready  = ~pending_q[issue_dest] | wr_hit[issue_dest];
    assign pending_mask = pending_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and model-checked bench for reg_file_scoreboard.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb0_en, wb1_en;
    logic [3:0]  wb0_dest, wb1_dest;
    logic [31:0] wb0_result, wb1_result;
    logic [3:0]  src1, src2, src3;
    logic [31:0] reg1, reg2, reg3;
    logic        hazard1, hazard2, hazard3;
    logic        issue_en;
    logic [3:0]  issue_dest;
    logic        issue_ready;
    logic        flush;
    logic [15:0] pending_mask;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    bit          m_valid = 0;

    reg_file_scoreboard #(
        .WORD_WIDTH(32), .ADDR_WIDTH(4), .RESET_INDEX(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wb0_en(wb0_en), .wb0_dest(wb0_dest), .wb0_result(wb0_result),
        .wb1_en(wb1_en), .wb1_dest(wb1_dest), .wb1_result(wb1_result),
        .src1(src1), .src2(src2), .src3(src3),
        .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .hazard1(hazard1), .hazard2(hazard2), .hazard3(hazard3),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .issue_ready(issue_ready), .flush(flush),
        .pending_mask(pending_mask)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural view: what a reader of register s sees this cycle.
    function automatic logic [31:0] m_read(input logic [3:0] s);
        if (wb1_en && wb1_dest == s) return wb1_result;
        if (wb0_en && wb0_dest == s) return wb0_result;
        return m_regs[s];
    endfunction

    function automatic bit m_written(input logic [3:0] s);
        return (wb0_en && wb0_dest == s) || (wb1_en && wb1_dest == s);
    endfunction

    function automatic bit m_hazard(input logic [3:0] s);
        return m_pend[s] && !m_written(s);
    endfunction

    task automatic m_update();
        logic [15:0] nxt;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = i;
            m_pend = '0;
            m_valid = 1;
        end else begin
            if (wb0_en) m_regs[wb0_dest] = wb0_result;
            if (wb1_en) m_regs[wb1_dest] = wb1_result;
            nxt = m_pend;
            if (wb0_en) nxt[wb0_dest] = 1'b0;
            if (wb1_en) nxt[wb1_dest] = 1'b0;
            if (issue_en) nxt[issue_dest] = 1'b1;
            if (flush) nxt = '0;
            m_pend = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        wb0_en = 0; wb1_en = 0; issue_en = 0; flush = 0; rst = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_reg1", reg1, m_read(src1));
                chk("m_reg2", reg2, m_read(src2));
                chk("m_reg3", reg3, m_read(src3));
                chk("m_hz1", {31'b0, hazard1}, {31'b0, m_hazard(src1)});
                chk("m_hz2", {31'b0, hazard2}, {31'b0, m_hazard(src2)});
                chk("m_hz3", {31'b0, hazard3}, {31'b0, m_hazard(src3)});
                chk("m_ready", {31'b0, issue_ready},
                    {31'b0, !m_pend[issue_dest] || m_written(issue_dest)});
                chk("m_pend", {16'b0, pending_mask}, {16'b0, m_pend});
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        wb0_dest = 0; wb1_dest = 0; wb0_result = 0; wb1_result = 0;
        issue_dest = 0; src1 = 5; src2 = 15; src3 = 0;
        tick();
        idle();
        @(negedge clk);
        chk("rst_reg1", reg1, 32'd5);
        chk("rst_reg2", reg2, 32'd15);
        chk("rst_reg3", reg3, 32'd0);
        chk("rst_pend", {16'b0, pending_mask}, 32'h0);
        chk("rst_ready", {31'b0, issue_ready}, 32'd1);

        tick();
        wb0_en = 1; wb0_dest = 3; wb0_result = 32'hAAAA0000;
        wb1_en = 1; wb1_dest = 3; wb1_result = 32'h5555FFFF;
        src1 = 3;
        @(negedge clk);
        chk("dual_byp", reg1, 32'h5555FFFF);
        tick();
        idle();
        @(negedge clk);
        chk("dual_reg", reg1, 32'h5555FFFF);

        tick();
        issue_en = 1; issue_dest = 7;
        tick();
        idle();
        src2 = 7;
        @(negedge clk);
        chk("raw_hz", {31'b0, hazard2}, 32'd1);
        chk("raw_pend", {16'b0, pending_mask}, 32'h0080);
        tick();
        tick();
        wb0_en = 1; wb0_dest = 7; wb0_result = 32'h1234;
        @(negedge clk);
        chk("raw_hz_wb", {31'b0, hazard2}, 32'd0);
        chk("raw_byp", reg2, 32'h1234);
        tick();
        idle();
        @(negedge clk);
        chk("raw_clr", {16'b0, pending_mask}, 32'h0);

        tick();
        issue_en = 1; issue_dest = 4;
        tick();
        wb1_en = 1; wb1_dest = 4; wb1_result = 32'hCAFE0004;
        issue_en = 1; issue_dest = 4;
        tick();
        idle();
        src3 = 4; issue_dest = 4;
        @(negedge clk);
        chk("sbc_pend4", {31'b0, pending_mask[4]}, 32'd1);
        chk("sbc_reg", reg3, 32'hCAFE0004);
        chk("sbc_ready", {31'b0, issue_ready}, 32'd0);
        chk("sbc_hz", {31'b0, hazard3}, 32'd1);

        tick();
        wb1_en = 1; wb1_dest = 4; wb1_result = 32'h44;
        tick();
        idle();
        issue_en = 1; issue_dest = 1;
        tick();
        issue_dest = 2;
        tick();
        issue_dest = 9;
        tick();
        idle();
        src1 = 1; src2 = 2; src3 = 9;
        @(negedge clk);
        chk("fl_pre", {16'b0, pending_mask}, 32'h0206);
        flush = 1; wb0_en = 1; wb0_dest = 2; wb0_result = 32'hBEEF;
        tick();
        idle();
        @(negedge clk);
        chk("fl_pend", {16'b0, pending_mask}, 32'h0);
        chk("fl_reg2", reg2, 32'hBEEF);
        chk("fl_hz", {29'b0, hazard1, hazard2, hazard3}, 32'd0);

        tick();
        issue_en = 1; issue_dest = 6;
        tick();
        idle();
        rst = 1; wb0_en = 1; wb0_dest = 6; wb0_result = 32'hFFFF;
        src1 = 6;
        tick();
        idle();
        @(negedge clk);
        chk("mid_reg6", reg1, 32'd6);
        chk("mid_pend", {16'b0, pending_mask}, 32'h0);

        for (int n = 0; n < 200; n++) begin
            tick();
            wb0_en = 1'($urandom_range(0, 1));
            wb1_en = 1'($urandom_range(0, 2) == 0);
            wb0_dest = 4'($urandom); wb1_dest = 4'($urandom);
            wb0_result = $urandom; wb1_result = $urandom;
            issue_en = 1'($urandom_range(0, 1));
            issue_dest = 4'($urandom);
            flush = 1'($urandom_range(0, 15) == 0);
            src1 = 4'($urandom); src2 = 4'($urandom); src3 = 4'($urandom);
            if (n % 4 == 0) begin
                src1 = wb0_dest; src2 = wb1_dest; src3 = issue_dest;
            end
        end
        tick();
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised successor to the core register file. It has three combinational read ports (Rn, Rm, Rs), two posedge write-back ports (ALU path and load path), and same-cycle write-through bypass. A per-register pending-write scoreboard sets bits at issue, clears them at write-back, and drives per-port hazard flags plus an issue-ready flag for the decode stall logic. A flush input clears all pending state on branch redirect.

Parameters:
WORD_WIDTH, 32, data width of each register
ADDR_WIDTH, 4, register index width; REG_COUNT = 2**ADDR_WIDTH (derived, not overridable)
RESET_INDEX, 1, 1: register i resets to value i; 0: all registers reset to 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb0_en  in  1  write enable, ALU write-back port
wb0_dest  in  ADDR_WIDTH  destination index, port 0
wb0_result  in  WORD_WIDTH  write data, port 0
wb1_en  in  1  write enable, load write-back port
wb1_dest  in  ADDR_WIDTH  destination index, port 1
wb1_result  in  WORD_WIDTH  write data, port 1
src1, src2, src3  in  ADDR_WIDTH each  read indices
reg1, reg2, reg3  out  WORD_WIDTH each  read data
hazard1, hazard2, hazard3  out  1 each  read value not yet valid
issue_en  in  1  instruction with a register destination issued this cycle
issue_dest  in  ADDR_WIDTH  destination of the issuing instruction
issue_ready  out  1  issue_dest has no pending write (WAW-safe)
flush  in  1  clear all pending bits
pending_mask  out  REG_COUNT  registered scoreboard state, bit i = register i pending

Behaviour:
- Reset (rst=1 at posedge): register i <- i if RESET_INDEX=1, else 0; pending_mask <- 0. Reset overrides all writes, issue and flush in the same cycle. Reset asserted mid-operation discards in-flight pending state; no write lands that cycle.
- Writes: at posedge, if wbN_en then regs[wbN_dest] <- wbN_result. Both ports may write in one cycle. If both enables are set and the dests are equal, port 1 (load) wins.
- Reads: combinational, zero latency.
  - regK = wb1_result if wb1_en and wb1_dest==srcK.
  - Else wb0_result if wb0_en and wb0_dest==srcK.
  - Else regs[srcK].
  - Bypass priority matches write priority.
- Scoreboard next-state per bit i, evaluated in this order:
  1. Clear if (wb0_en and wb0_dest==i) or (wb1_en and wb1_dest==i).
  2. Then set if issue_en and issue_dest==i. Set beats clear on the same index, because the new producer supersedes the completing one.
  3. flush=1 forces all bits to 0, overriding both set and clear.
  4. Writes still commit during flush.
- hazardK = pending_mask[srcK] AND NOT (write to srcK this cycle on either port). A bypassed value is valid, so there is no hazard.
- issue_ready = NOT pending_mask[issue_dest] OR (write to issue_dest this cycle). It is combinational and independent of issue_en.
- The block never stalls internally. Issuing with issue_ready=0 is legal: the bit stays set, there is no error.
- All outputs are defined from the cycle after reset:
  - reg outputs reflect the reset contents.
  - hazards = 0.
  - issue_ready = 1.
  - pending_mask = 0.
- No special handling of index 15 (PC). Upper pipeline logic owns PC semantics.
- Width rules: indices are unsigned. All REG_COUNT entries are physically present. Data passes unmodified, with no sign or zero extension.

Test Plan:
- Reset value: rst=1 for 1 cycle, RESET_INDEX=1, src1=5, src2=15, src3=0 -> reg1=5, reg2=15, reg3=0, pending_mask=0, issue_ready=1.
- Dual write, same dest: wb0_en=1 (dest 3, 0xAAAA0000), wb1_en=1 (dest 3, 0x5555FFFF), src1=3 -> reg1=0x5555FFFF in the same cycle; next cycle with wb off, reg1=0x5555FFFF.
- Scoreboard RAW:
  - Cycle 0: issue_en=1, issue_dest=7.
  - Cycle 1: src2=7 -> hazard2=1, pending_mask=0x0080.
  - Cycle 3: wb0_en=1, dest 7, 0x1234 -> hazard2=0 and reg2=0x1234 (bypass) that cycle.
  - Cycle 4: pending_mask=0.
- Set beats clear: with r4 pending, one cycle with wb1_en=1 (dest 4) and issue_en=1 (dest 4) -> next cycle pending_mask[4]=1, reg4 holds the written value, and issue_ready=0 for issue_dest=4.
- Flush: pend r1, r2, r9, then flush=1 with wb0_en=1 (dest 2, 0xBEEF) -> next cycle pending_mask=0, regs[2]=0xBEEF, all hazards 0.
- Reset mid-op: r6 pending, rst=1 with wb0_en=1 (dest 6, 0xFFFF) -> next cycle regs[6]=6, pending_mask=0.
